axi_bus_arbiter: RTL and testbench
==================================

AXI_BUS_ARBITER -- requirements
Module: axi_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning AXI-Lite address width.
REQ-002 SHALL have port AXI_CLK  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port RESETN  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_i  input  2  per-requester command request, level; bit0 = i8088 bus bridge, bit1 = debug/loader.
REQ-005 SHALL have port we_i  input  2  per-requester 1 = write, 0 = read.
REQ-006 SHALL have port addr_i  input  2*ADDR_W  per-requester address, requester n at [n*ADDR_W +: ADDR_W].
REQ-007 SHALL have port wdata_i  input  64  per-requester write data, requester n at [n*32 +: 32].
REQ-008 SHALL have port wstrb_i  input  8  per-requester byte strobes, requester n at [n*4 +: 4].
REQ-009 SHALL have port done_o  output  2  one-cycle completion pulse to the granted requester.
REQ-010 SHALL have port rdata_o  output  32  read data, valid while done_o is nonzero.
REQ-011 SHALL have port resp_o  output  2  AXI response code, valid while done_o is nonzero.
REQ-012 SHALL have AXI-Lite master ports AXI_awaddr(out ADDR_W), AXI_awvalid(out), AXI_awready(in), AXI_wdata(out 32), AXI_wstrb(out 4), AXI_wvalid(out), AXI_wready(in), AXI_bresp(in 2), AXI_bvalid(in), AXI_bready(out).
REQ-013 SHALL have AXI-Lite master ports AXI_araddr(out ADDR_W), AXI_arvalid(out), AXI_arready(in), AXI_rdata(in 32), AXI_rresp(in 2), AXI_rvalid(in), AXI_rready(out).

Function
REQ-014 SHALL implement states IDLE, WADDR (AW/W outstanding), WRESP, RADDR, RDATA, DONE; one transaction in flight at a time.
REQ-015 SHALL, in IDLE with any req_i set, grant one requester on that edge, register its command, and enter WADDR (we=1) or RADDR (we=0).
REQ-016 SHALL arbitrate round-robin: with both requests pending, grant the requester not granted last; after reset, requester 0 wins the first tie.
REQ-017 SHALL, in WADDR, assert AXI_awvalid and AXI_wvalid together and drop each independently on its own handshake; enter WRESP only after both handshakes complete (same or different cycles).
REQ-018 SHALL, in WRESP, hold AXI_bready=1; on bvalid&bready, capture bresp into resp_o and enter DONE.
REQ-019 SHALL, in RADDR, hold AXI_arvalid until arready; then enter RDATA with AXI_rready=1; on rvalid&rready, capture rdata and rresp and enter DONE.
REQ-020 SHALL, in DONE, pulse done_o for the granted bit for exactly one cycle, then return to IDLE.
REQ-021 SHALL keep AXI address, data and strobe outputs stable while the corresponding valid is high (AXI rule).
REQ-022 SHALL hold rdata_o unchanged across write transactions; resp_o updates on every transaction.
REQ-023 SHALL assert bready/rready only in WRESP/RDATA; bvalid/rvalid in other states SHALL be ignored.
REQ-024 SHALL have zero-wait-slave latency of 3 cycles: req sampled at edge 0, valids high after edge 0, done_o high after edge 2.
REQ-025 SHALL treat a req_i bit still high in the cycle after its done_o pulse as a new request; requesters deassert req_i on the edge where they see done_o.
REQ-026 SHALL not change the grant or command while a transaction is in flight, regardless of req_i activity.

Reset
REQ-027 SHALL, while RESETN=0, force the state to IDLE, every AXI valid/ready output and done_o to 0, and rdata_o/resp_o to 0, and set last-grant so that requester 0 has priority.
REQ-028 SHALL abandon any in-flight transaction on reset mid-operation, with no done_o pulse for it.

Verification
REQ-029 SHALL verify read: req_i=01, we=0, addr 0x0000_1000, slave rdata 0xDEADBEEF with zero wait -> done_o=01 three cycles later, rdata_o=0xDEADBEEF, resp_o=0.
REQ-030 SHALL verify write with awready 2 cycles before wready: wdata 0x12345678, wstrb F -> bready asserted only after wready; done_o=10 one cycle after bvalid, resp_o=bresp.
REQ-031 SHALL verify arbitration: both req held for 4 back-to-back transactions -> grant order 0,1,0,1.
REQ-032 SHALL verify SLVERR: rresp=2 -> resp_o=2 and done_o pulsed; no hang.
REQ-033 SHALL verify reset: RESETN low while in WRESP -> all valids and bready 0 immediately, no done_o; after release, req 11 -> requester 0 granted first.

Source files
------------

// File: rtl/axi_bus_arbiter_if.sv
// AXI-Lite bus bundle between the arbiter (master) and the downstream slave.
//
// Signals:
//   awaddr/awvalid/awready  write address channel
//   wdata/wstrb/wvalid/wready  write data channel
//   bresp/bvalid/bready     write response channel
//   araddr/arvalid/arready  read address channel
//   rdata/rresp/rvalid/rready  read data channel
//
// Modports:
//   master  drives the address/data/valid signals and the response readies
//   slave   drives the readies for address/data and the response valids
interface axi_bus_arbiter_if #(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a single AXI-Lite master port.
// Requester 0 is the i8088 bus bridge, requester 1 the debug/loader port.
// One transaction is in flight at a time; the granted requester receives a
// single-cycle done_o pulse together with the response (and read data).
//
// Ports:
//   AXI_CLK   clock, all logic on the rising edge
//   RESETN    asynchronous active-low reset
//   req_i     per-requester level request
//   we_i      per-requester direction, 1 = write
//   addr_i    per-requester address, requester n at [n*ADDR_W +: ADDR_W]
//   wdata_i   per-requester write data, requester n at [n*32 +: 32]
//   wstrb_i   per-requester byte strobes, requester n at [n*4 +: 4]
//   done_o    one-cycle completion pulse, one bit per requester
//   rdata_o   read data of the last read, held across writes
//   resp_o    AXI response of the last transaction
//   AXI       AXI-Lite master port (axi_bus_arbiter_if.master)
module axi_bus_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic                  AXI_CLK,
  input  logic                  RESETN,
  input  logic [1:0]            req_i,
  input  logic [1:0]            we_i,
  input  logic [2*ADDR_W-1:0]   addr_i,
  input  logic [63:0]           wdata_i,
  input  logic [7:0]            wstrb_i,
  output logic [1:0]            done_o,
  output logic [31:0]           rdata_o,
  output logic [1:0]            resp_o,
  axi_bus_arbiter_if.master     AXI
);

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WRESP,
    RADDR,
    RDATA,
    DONE
  } state_t;

  state_t            state;
  logic              grant_idx;
  logic              last_grant;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  logic [3:0]        cmd_wstrb;
  logic              awvalid_q;
  logic              wvalid_q;
  logic              bready_q;
  logic              arvalid_q;
  logic              rready_q;

  logic              pick;
  logic              aw_left;
  logic              w_left;
  logic [1:0]        grant_onehot;

  // On a tie the requester that was not granted last wins; otherwise the
  // single active requester is taken.
  assign pick = (req_i == 2'b11) ? ~last_grant : req_i[1];

  // A channel is still outstanding if its valid is up and this cycle is not
  // its handshake; the write phase ends once neither channel is outstanding.
  assign aw_left = awvalid_q & ~AXI.awready;
  assign w_left  = wvalid_q & ~AXI.wready;

  assign grant_onehot = grant_idx ? 2'b10 : 2'b01;

  // The command registers feed both address channels directly, so they stay
  // stable for the whole transaction.
  assign AXI.awaddr  = cmd_addr;
  assign AXI.araddr  = cmd_addr;
  assign AXI.wdata   = cmd_wdata;
  assign AXI.wstrb   = cmd_wstrb;
  assign AXI.awvalid = awvalid_q;
  assign AXI.wvalid  = wvalid_q;
  assign AXI.bready  = bready_q;
  assign AXI.arvalid = arvalid_q;
  assign AXI.rready  = rready_q;

  always_ff @(posedge AXI_CLK or negedge RESETN) begin
    if (!RESETN) begin
      state      <= IDLE;
      grant_idx  <= 1'b0;
      // Marking requester 1 as last granted gives requester 0 the first tie.
      last_grant <= 1'b1;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      cmd_wstrb  <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      done_o     <= 2'b00;
      rdata_o    <= '0;
      resp_o     <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (|req_i) begin
            grant_idx  <= pick;
            last_grant <= pick;
            cmd_addr   <= pick ? addr_i[2*ADDR_W-1 -: ADDR_W] : addr_i[ADDR_W-1:0];
            cmd_wdata  <= pick ? wdata_i[63:32] : wdata_i[31:0];
            cmd_wstrb  <= pick ? wstrb_i[7:4] : wstrb_i[3:0];
            if (we_i[pick]) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= WADDR;
            end else begin
              arvalid_q <= 1'b1;
              state     <= RADDR;
            end
          end
        end

        WADDR: begin
          if (AXI.awready) awvalid_q <= 1'b0;
          if (AXI.wready)  wvalid_q  <= 1'b0;
          if (!aw_left && !w_left) begin
            bready_q <= 1'b1;
            state    <= WRESP;
          end
        end

        WRESP: begin
          if (AXI.bvalid) begin
            resp_o   <= AXI.bresp;
            bready_q <= 1'b0;
            done_o   <= grant_onehot;
            state    <= DONE;
          end
        end

        RADDR: begin
          if (AXI.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= RDATA;
          end
        end

        RDATA: begin
          if (AXI.rvalid) begin
            rdata_o  <= AXI.rdata;
            resp_o   <= AXI.rresp;
            rready_q <= 1'b0;
            done_o   <= grant_onehot;
            state    <= DONE;
          end
        end

        DONE: begin
          done_o <= 2'b00;
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_bus_arbiter.sv
// Self-checking bench for axi_bus_arbiter: directed scenarios with literal
// expectations followed by randomized requesters and a randomized slave.
// A transaction-level model tracks which channels must be outstanding and
// what the requester-side outputs must hold; a negedge process compares the
// DUT against it every cycle.
module tb_axi_bus_arbiter;

  localparam int ADDR_W = 32;

  logic                AXI_CLK = 1'b0;
  logic                RESETN  = 1'b0;
  logic [1:0]          req_i   = '0;
  logic [1:0]          we_i    = '0;
  logic [2*ADDR_W-1:0] addr_i  = '0;
  logic [63:0]         wdata_i = '0;
  logic [7:0]          wstrb_i = '0;
  logic [1:0]          done_o;
  logic [31:0]         rdata_o;
  logic [1:0]          resp_o;

  axi_bus_arbiter_if #(.ADDR_W(ADDR_W)) axi ();

  axi_bus_arbiter #(.ADDR_W(ADDR_W)) dut (
    .AXI_CLK (AXI_CLK),
    .RESETN  (RESETN),
    .req_i   (req_i),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .wstrb_i (wstrb_i),
    .done_o  (done_o),
    .rdata_o (rdata_o),
    .resp_o  (resp_o),
    .AXI     (axi)
  );

  always #5 AXI_CLK = ~AXI_CLK;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Transaction-level model of what the arbiter must present.
  logic              m_busy, m_we, m_new;
  logic              m_aw_pend, m_w_pend, m_b_wait, m_ar_pend, m_r_wait;
  int                m_idx, m_last;
  logic [1:0]        m_done, m_resp;
  logic [31:0]       m_rdata, m_wdata;
  logic [3:0]        m_wstrb;
  logic [ADDR_W-1:0] m_addr;

  // Slave behaviour knobs: per-channel wait cycles and response values.
  int          dly_aw, dly_w, dly_b, dly_ar, dly_r;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [1:0]  bresp_val, rresp_val;
  logic [31:0] rdata_val;
  bit          rand_mode = 1'b0;
  bit          noise_en  = 1'b0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_we = 0; m_new = 0;
    m_aw_pend = 0; m_w_pend = 0; m_b_wait = 0; m_ar_pend = 0; m_r_wait = 0;
    m_idx = 0; m_last = 1;
    m_done = 0; m_resp = 0; m_rdata = 0; m_wdata = 0; m_wstrb = 0; m_addr = 0;
  endtask

  // One clock edge of the model, using the inputs the bench is driving.
  task automatic model_step();
    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
    aw_hs = m_aw_pend && axi.awready;
    w_hs  = m_w_pend && axi.wready;
    ar_hs = m_ar_pend && axi.arready;
    b_hs  = m_b_wait && axi.bvalid;
    r_hs  = m_r_wait && axi.rvalid;
    m_new = 0;
    if (m_done != 0) begin
      m_done = 0;
    end else if (!m_busy) begin
      if (req_i != 0) begin
        if (req_i == 2'b11) m_idx = 1 - m_last;
        else                m_idx = req_i[1] ? 1 : 0;
        m_last  = m_idx;
        m_busy  = 1;
        m_new   = 1;
        m_we    = we_i[m_idx];
        m_addr  = addr_i[m_idx*ADDR_W +: ADDR_W];
        m_wdata = wdata_i[m_idx*32 +: 32];
        m_wstrb = wstrb_i[m_idx*4 +: 4];
        if (m_we) begin m_aw_pend = 1; m_w_pend = 1; end
        else      m_ar_pend = 1;
      end
    end else if (b_hs) begin
      m_resp = axi.bresp; m_b_wait = 0; m_busy = 0;
      m_done = (m_idx == 1) ? 2'b10 : 2'b01;
    end else if (r_hs) begin
      m_rdata = axi.rdata; m_resp = axi.rresp; m_r_wait = 0; m_busy = 0;
      m_done = (m_idx == 1) ? 2'b10 : 2'b01;
    end else begin
      if (aw_hs) m_aw_pend = 0;
      if (w_hs)  m_w_pend  = 0;
      if (m_we && !m_aw_pend && !m_w_pend && !m_b_wait) m_b_wait = 1;
      if (ar_hs) begin m_ar_pend = 0; m_r_wait = 1; end
    end
  endtask

  task automatic drive_slave();
    if (m_new) begin
      if (rand_mode) begin
        dly_aw = $urandom_range(0, 3); dly_w = $urandom_range(0, 3);
        dly_b  = $urandom_range(0, 3); dly_ar = $urandom_range(0, 3);
        dly_r  = $urandom_range(0, 3);
        bresp_val = 2'($urandom); rresp_val = 2'($urandom); rdata_val = $urandom;
      end
      aw_cnt = dly_aw; w_cnt = dly_w; b_cnt = dly_b; ar_cnt = dly_ar; r_cnt = dly_r;
    end
    if (m_aw_pend) begin axi.awready = (aw_cnt == 0); if (aw_cnt > 0) aw_cnt--; end
    else axi.awready = noise_en ? 1'($urandom % 2) : 1'b0;
    if (m_w_pend) begin axi.wready = (w_cnt == 0); if (w_cnt > 0) w_cnt--; end
    else axi.wready = noise_en ? 1'($urandom % 2) : 1'b0;
    if (m_ar_pend) begin axi.arready = (ar_cnt == 0); if (ar_cnt > 0) ar_cnt--; end
    else axi.arready = noise_en ? 1'($urandom % 2) : 1'b0;
    if (m_b_wait) begin
      axi.bvalid = (b_cnt == 0); axi.bresp = bresp_val;
      if (b_cnt > 0) b_cnt--;
    end else begin
      axi.bvalid = noise_en && ($urandom % 5 == 0); axi.bresp = 2'($urandom);
    end
    if (m_r_wait) begin
      axi.rvalid = (r_cnt == 0); axi.rdata = rdata_val; axi.rresp = rresp_val;
      if (r_cnt > 0) r_cnt--;
    end else begin
      axi.rvalid = noise_en && ($urandom % 5 == 0);
      axi.rdata = $urandom; axi.rresp = 2'($urandom);
    end
  endtask

  task automatic new_cmd(input int n);
    we_i[n] = 1'($urandom);
    addr_i[n*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
    wdata_i[n*32 +: 32] = $urandom;
    wstrb_i[n*4 +: 4] = 4'($urandom);
  endtask

  // Random requesters: drop the request when done is seen (sometimes
  // re-requesting at once with a new command), raise new requests at random.
  task automatic apply_stimulus();
    for (int n = 0; n < 2; n++) begin
      if (m_done[n]) begin
        if ($urandom % 4 == 0) new_cmd(n);
        else req_i[n] = 1'b0;
      end else if (!req_i[n] && ($urandom % 3 == 0)) begin
        req_i[n] = 1'b1;
        new_cmd(n);
      end
    end
  endtask

  task automatic tick();
    @(posedge AXI_CLK);
    if (RESETN) model_step();
    @(negedge AXI_CLK);
    drive_slave();
    if (rand_mode) apply_stimulus();
  endtask

  // Cycle-by-cycle comparison of the DUT against the model.
  always @(negedge AXI_CLK) begin
    if (chk_en && RESETN) begin
      check_output("awvalid", axi.awvalid, m_aw_pend);
      check_output("wvalid", axi.wvalid, m_w_pend);
      check_output("bready", axi.bready, m_b_wait);
      check_output("arvalid", axi.arvalid, m_ar_pend);
      check_output("rready", axi.rready, m_r_wait);
      check_output("done_o", done_o, m_done);
      check_output("rdata_o", rdata_o, m_rdata);
      check_output("resp_o", resp_o, m_resp);
      if (m_aw_pend) check_output("awaddr", axi.awaddr, m_addr);
      if (m_w_pend) begin
        check_output("wdata", axi.wdata, m_wdata);
        check_output("wstrb", axi.wstrb, m_wstrb);
      end
      if (m_ar_pend) check_output("araddr", axi.araddr, m_addr);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not reach the end");
    $fatal(1, "[TB] timeout");
  end

  logic [1:0] seen [4];
  logic [1:0] arb_exp [4];
  logic [1:0] first_done;
  int         n_seen;

  initial begin
    axi.awready = 0; axi.wready = 0; axi.arready = 0;
    axi.bvalid = 0; axi.bresp = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
    dly_aw = 0; dly_w = 0; dly_b = 0; dly_ar = 0; dly_r = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    bresp_val = 0; rresp_val = 0; rdata_val = 0;
    arb_exp[0] = 2'b01; arb_exp[1] = 2'b10; arb_exp[2] = 2'b01; arb_exp[3] = 2'b10;
    for (int k = 0; k < 4; k++) seen[k] = 2'b00;
    model_reset();

    repeat (3) @(negedge AXI_CLK);
    check_output("reset_done", done_o, 2'b00);
    check_output("reset_rdata", rdata_o, 32'h0);
    check_output("reset_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 5'b0);
    #2 RESETN = 1'b1;
    chk_en = 1'b1;

    // Zero-wait read from requester 0.
    $display("[TB] read, zero wait");
    rdata_val = 32'hDEAD_BEEF; rresp_val = 2'b00;
    req_i = 2'b01; we_i = 2'b00; addr_i[31:0] = 32'h0000_1000;
    tick();
    check_output("rd_arvalid", axi.arvalid, 1'b1);
    check_output("rd_araddr", axi.araddr, 32'h0000_1000);
    tick();
    check_output("rd_rready", axi.rready, 1'b1);
    tick();
    check_output("rd_done", done_o, 2'b01);
    check_output("rd_rdata", rdata_o, 32'hDEAD_BEEF);
    check_output("rd_resp", resp_o, 2'b00);
    req_i = 2'b00;
    tick();
    check_output("rd_done_drop", done_o, 2'b00);

    // Write from requester 1 with awready two cycles ahead of wready.
    $display("[TB] write, awready before wready");
    dly_aw = 0; dly_w = 2; dly_b = 0; bresp_val = 2'b01;
    req_i = 2'b10; we_i = 2'b10; addr_i[63:32] = 32'h0000_2000;
    wdata_i[63:32] = 32'h1234_5678; wstrb_i[7:4] = 4'hF;
    tick();
    check_output("wr_wdata", axi.wdata, 32'h1234_5678);
    check_output("wr_wstrb", axi.wstrb, 4'hF);
    tick();
    check_output("wr_aw_dropped", {axi.awvalid, axi.wvalid}, 2'b01);
    tick();
    check_output("wr_bready_early", axi.bready, 1'b0);
    tick();
    check_output("wr_bready", axi.bready, 1'b1);
    tick();
    check_output("wr_done", done_o, 2'b10);
    check_output("wr_resp", resp_o, 2'b01);
    check_output("wr_rdata_held", rdata_o, 32'hDEAD_BEEF);
    req_i = 2'b00;
    tick();

    // Both requesters held: grants must alternate starting with requester 0.
    $display("[TB] round-robin");
    dly_w = 0; bresp_val = 2'b00; rdata_val = 32'hCAFE_0001;
    req_i = 2'b11; we_i = 2'b01; addr_i = {32'h0000_3004, 32'h0000_3000};
    wdata_i[31:0] = 32'hA5A5_0001; wstrb_i[3:0] = 4'h3;
    n_seen = 0;
    for (int c = 0; c < 40 && n_seen < 4; c++) begin
      tick();
      if (done_o != 2'b00) begin
        seen[n_seen] = done_o;
        n_seen++;
        if (n_seen == 4) req_i = 2'b00;
      end
    end
    check_output("arb_count", n_seen, 4);
    for (int k = 0; k < 4; k++) check_output("arb_order", seen[k], arb_exp[k]);
    tick();

    // Slave error on a read.
    $display("[TB] read SLVERR");
    rdata_val = 32'h0BAD_F00D; rresp_val = 2'b10;
    req_i = 2'b01; we_i = 2'b00; addr_i[31:0] = 32'h0000_4000;
    repeat (3) tick();
    check_output("slverr_done", done_o, 2'b01);
    check_output("slverr_resp", resp_o, 2'b10);
    req_i = 2'b00;
    tick();

    // Reset while waiting for the write response.
    $display("[TB] reset during write response");
    rresp_val = 2'b00; dly_b = 20;
    req_i = 2'b01; we_i = 2'b01; addr_i[31:0] = 32'h0000_5000;
    tick();
    tick();
    check_output("rst_wresp_bready", axi.bready, 1'b1);
    #2 RESETN = 1'b0;
    model_reset();
    req_i = 2'b00;
    #1;
    check_output("rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 5'b0);
    check_output("rst_done", done_o, 2'b00);
    check_output("rst_resp", resp_o, 2'b00);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_output("rst_hold_done", done_o, 2'b00);
    end
    #2 RESETN = 1'b1;
    dly_b = 0; rdata_val = 32'h7777_0000;
    req_i = 2'b11; we_i = 2'b00; addr_i = {32'h0000_6004, 32'h0000_6000};
    first_done = 2'b00;
    for (int c = 0; c < 12 && first_done == 2'b00; c++) begin
      tick();
      if (done_o != 2'b00) first_done = done_o;
    end
    check_output("rst_first_grant", first_done, 2'b01);
    req_i = 2'b00;
    tick();
    tick();

    // Random traffic from both requesters against a random-latency slave.
    $display("[TB] random traffic");
    rand_mode = 1'b1;
    noise_en  = 1'b1;
    repeat (3000) tick();
    rand_mode = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
